// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the simple-dual-port RAM
// and its clear engine.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clear_state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every address writing zero after reset or on request,
// and owns the write port (dropping external writes) while it does so.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  wr_drop,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  clear_state_e          state;
  logic [ADDR_WIDTH-1:0] clear_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clear_cnt <= '0;
      busy      <= 1'b1;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state == CLEAR);
      case (state)
        CLEAR: begin
          // Natural wrap brings clear_cnt back to zero on the exit edge.
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear_start) begin
            state     <= CLEAR;
            clear_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mem_we    = wr_en;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clear_cnt;
      mem_wdata = '0;
    end
  end

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised simple-dual-port RAM with clear engine and aligned read-valid.
// Define RAM_BYPASS_EN for write-first forwarding on same-address read/write.
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_start,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_drop,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("ram_sdp_param: READ_LATENCY must be 1 or 2");
  end

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_valid_s1;
  logic [DATA_WIDTH-1:0] rd_data_s1;

  ram_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clear_start(clear_start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .wr_drop    (wr_drop),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

`ifdef RAM_BYPASS_EN
  always_comb begin
    rd_word = mem[rd_addr];
    if (mem_we && (mem_addr == rd_addr)) rd_word = mem_wdata;
  end
`else
  always_comb begin
    rd_word = mem[rd_addr];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_s1 <= 1'b0;
      rd_data_s1  <= '0;
    end else begin
      rd_valid_s1 <= rd_en;
      if (rd_en) rd_data_s1 <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd_valid_s2;
    logic [DATA_WIDTH-1:0] rd_data_s2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid_s2 <= 1'b0;
        rd_data_s2  <= '0;
      end else begin
        rd_valid_s2 <= rd_valid_s1;
        if (rd_valid_s1) rd_data_s2 <= rd_data_s1;
      end
    end

    assign rd_valid = rd_valid_s2;
    assign rd_data  = rd_data_s2;
  end else begin : g_lat1
    assign rd_valid = rd_valid_s1;
    assign rd_data  = rd_data_s1;
  end

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param: latency-1 and latency-2 instances share
// stimulus; each has a scoreboard of expected read data and arrival cycle.
module tb_ram_sdp_param;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        busy1, wr_drop1, rd_valid1;
  logic [31:0] rd_data1;
  logic        busy2, wr_drop2, rd_valid2;
  logic [31:0] rd_data2;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        e1, e2;
  logic [31:0] m [16];

  ram_sdp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  ram_sdp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop2),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid1) begin
      if (q1.size() == 0) check("rd1_unexpected_valid", {31'b0, rd_valid1}, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("rd1_data", rd_data1, e1.data);
        check("rd1_cycle", cyc, e1.due);
      end
    end
    if (rd_valid2) begin
      if (q2.size() == 0) check("rd2_unexpected_valid", {31'b0, rd_valid2}, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("rd2_data", rd_data2, e2.data);
        check("rd2_cycle", cyc, e2.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_step(input logic [3:0] a, input logic [31:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    q1.push_back('{d, cyc + 1});
    q2.push_back('{d, cyc + 2});
  endtask

  task automatic write_one(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    m[a]    = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_seq(input int unsigned first, input int unsigned count);
    for (int unsigned i = first; i < first + count; i++) begin
      read_step(i[3:0], m[i[3:0]]);
      tick();
    end
    rd_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_clear(input string tag, input int unsigned expn);
    int unsigned n = 0;
    while (busy1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, expn);
    check({tag, "_dut2"}, {31'b0, busy2}, 32'd0);
    for (int i = 0; i < 16; i++) m[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] same_exp;
    for (int i = 0; i < 16; i++) m[i] = '0;

    repeat (3) tick();
    check("reset_busy1", {31'b0, busy1}, 32'd1);
    check("reset_busy2", {31'b0, busy2}, 32'd1);
    check("reset_wr_drop1", {31'b0, wr_drop1}, 32'd0);
    check("reset_rd_valid1", {31'b0, rd_valid1}, 32'd0);
    check("reset_rd_data1", rd_data1, 32'd0);
    check("reset_rd_valid2", {31'b0, rd_valid2}, 32'd0);
    check("reset_rd_data2", rd_data2, 32'd0);
    rst = 1'b0;
    wait_clear("busy_after_reset", 16);

    read_seq(0, 16);

    write_one(4'd4, 32'hDEADBEEF);
    check("wr_drop_idle_write", {31'b0, wr_drop1}, 32'd0);
    read_step(4'd4, m[4]);
    tick();
    read_step(4'd5, m[5]);
    tick();
    rd_en = 1'b0;
    repeat (3) tick();

    write_one(4'd7, 32'h00000001);
`ifdef RAM_BYPASS_EN
    same_exp = 32'hCAFEF00D;
`else
    same_exp = 32'h00000001;
`endif
    read_step(4'd7, same_exp);
    write_one(4'd7, 32'hCAFEF00D);
    rd_en = 1'b0;
    read_step(4'd7, 32'hCAFEF00D);
    tick();
    read_step(4'd4, 32'hDEADBEEF);
    write_one(4'd8, 32'h00000088);
    read_step(4'd8, 32'h00000088);
    tick();
    rd_en = 1'b0;
    repeat (3) tick();
    check("rd_data1_hold", rd_data1, 32'h00000088);
    check("rd_data2_hold", rd_data2, 32'h00000088);

    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("busy_after_clear_start", {31'b0, busy1}, 32'd1);
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 32'h33333333;
    tick();
    wr_en = 1'b0;
    check("wr_drop1_pulse", {31'b0, wr_drop1}, 32'd1);
    check("wr_drop2_pulse", {31'b0, wr_drop2}, 32'd1);
    tick();
    check("wr_drop1_single", {31'b0, wr_drop1}, 32'd0);
    wait_clear("busy_clear_start", 14);
    read_seq(3, 6);

    for (int unsigned i = 0; i < 16; i++) write_one(i[3:0], 32'hA5000000 | (i * 32'h00010101));
    read_seq(0, 16);

    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (7) tick();
    rd_en   = 1'b1;
    rd_addr = 4'd15;
    tick();
    rst   = 1'b1;
    rd_en = 1'b0;
    #1;
    check("flush_rd_valid1", {31'b0, rd_valid1}, 32'd0);
    check("flush_rd_valid2", {31'b0, rd_valid2}, 32'd0);
    check("flush_busy1", {31'b0, busy1}, 32'd1);
    tick();
    tick();
    check("flush_rd_valid2_held", {31'b0, rd_valid2}, 32'd0);
    rst = 1'b0;
    wait_clear("busy_after_midclear_reset", 16);
    read_seq(0, 16);

    check("sb1_drained", q1.size(), 32'd0);
    check("sb2_drained", q2.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sdp_param.md
# ram_sdp_param

Parametrised simple-dual-port RAM for the range-limited MD pipeline: one write port and one read port on a single clock, configurable width, depth and read latency. It adds an aligned read-valid strobe, a hardware clear engine that zeroes the whole array after reset or on request, and defined read-during-write behaviour. It replaces the fixed 32x4096 single-port test RAM as the generic storage primitive for particle and force caches.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 12, address width; depth = 2**ADDR_WIDTH words
- READ_LATENCY, 1, 1 or 2 cycles; 2 adds an output register stage
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clear_start  in  1  one-cycle request to zero the array; honoured only in IDLE
- busy  out  1  high while the clear engine owns the write port
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_drop  out  1  one-cycle pulse: wr_en was asserted while busy and was discarded
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data, valid when rd_valid
- rd_valid  out  1  high exactly READ_LATENCY cycles after an accepted rd_en

## Operation
- Clear FSM states: CLEAR, IDLE. Reset forces CLEAR with clear_cnt=0.
- CLEAR: every edge writes 0 to clear_cnt, increments; after writing address DEPTH-1 -> IDLE. clear_cnt wraps to 0 on exit.
- IDLE: clear_start -> CLEAR, clear_cnt=0. clear_start while busy is ignored (no restart, no queueing).
- Writes: wr_en in IDLE writes wr_data to wr_addr at the edge. wr_en while busy is dropped and pulses wr_drop on the next cycle.
- Reads: rd_en accepted in any state, including CLEAR; returns array contents at the read edge (zero or pre-clear data depending on clear progress).
- Read-during-write, same address, same edge: returns old data (read-before-write) unless RAM_BYPASS_EN (see Configuration).
- Simultaneous rd_en and wr_en at different addresses: independent, no stall.
- rd_data holds its last value when rd_valid is low.
- Reset mid-clear or mid-read: clear restarts from 0; in-flight reads are discarded (rd_valid pipeline flushed).

## Timing
- Reset values: busy=1, wr_drop=0, rd_valid=0, rd_data=0, state=CLEAR, clear_cnt=0.
- busy stays high for exactly 2**ADDR_WIDTH rising edges after rst deasserts; falls on the edge that writes DEPTH-1.
- First external write accepted on the edge after busy falls.
- clear_start sampled high at edge N in IDLE: busy=1 after edge N; first zero written at edge N+1.
- READ_LATENCY=1: rd_en at edge N -> rd_data/rd_valid after edge N+1... updated at edge N, visible cycle N+1. READ_LATENCY=2: visible cycle N+2.
- Back-to-back rd_en every cycle gives one result per cycle; full throughput.
- wr_drop asserted one cycle after the rejected edge, for one cycle.

## Configuration
- RAM_BYPASS_EN defined: same-address read and write on one edge return wr_data (write-first forwarding mux on read path); also applies during CLEAR (returns 0 when clear_cnt==rd_addr).
- RAM_BYPASS_EN undefined: read-before-write; old contents returned; no forwarding logic synthesised.

## Structure
- Package ram_pkg: clear FSM state enum (CLEAR, IDLE), READ_LATENCY legal-values constants, elaboration check function for READ_LATENCY in {1,2}.
- Sub-module ram_clear_fsm: state register, clear_cnt, busy, and write-port mux (clear vs external); array and read pipeline stay in the top.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=32: release rst -> busy high exactly 16 cycles; then read all 16 addresses -> every rd_data=0, rd_valid each after READ_LATENCY.
- Write 32'hDEADBEEF to addr 4, read addr 4 next cycle -> 32'hDEADBEEF; read addr 5 -> 0.
- wr_en to addr 3 during busy -> wr_drop pulse one cycle later; after clear, addr 3 reads 0.
- Same-edge write 32'hCAFEF00D and read addr 7 (held 32'h1) -> 32'h1 without RAM_BYPASS_EN, 32'hCAFEF00D with it.
- Fill all addresses, pulse clear_start, assert rst at clear cycle 8 -> rd_valid flushed, busy high 16 further cycles, all reads 0.
- READ_LATENCY=2: rd_en every cycle for addrs 0..15 -> rd_valid contiguous 16 cycles starting 2 cycles after first rd_en, data in order.
